fcfs_arbiter: RTL
=================

FCFS_ARBITER -- requirements
Module: fcfs_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of requesters (range 2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of grant cycles before forced revoke (0 disables the timeout).
REQ-003 The block SHALL derive localparam IDW = max(1, clog2(N_REQ)) and localparam CW = clog2(N_REQ+1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester level request, held high while the resource is wanted.
REQ-007 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, or all zero.
REQ-008 The block SHALL have port gnt_id, output, IDW bits: index of the granted requester; 0 when none is granted.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any gnt bit is high.
REQ-010 The block SHALL have port q_count, output, CW bits: number of entries currently in the wait queue.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse marking a forced revoke.

Function
REQ-012 The block SHALL register req each cycle (req_d) and detect an arrival for requester i when req[i]=1 and req_d[i]=0.
REQ-013 The block SHALL keep a circular FIFO of requester indices, depth N_REQ, with read and write pointers that wrap modulo N_REQ.
REQ-014 The block SHALL keep a per-requester in_q flag and SHALL ignore an arrival while that requester's in_q is set, so the FIFO cannot overflow.
REQ-015 The block SHALL enqueue all arrivals sampled in one cycle at that edge, in ascending index order (lowest index nearest the head).
REQ-016 The block SHALL implement the state machine IDLE -> GRANT -> IDLE, where IDLE is resource free and GRANT is resource owned by gnt_id.
REQ-017 In IDLE with q_count>0, the block SHALL pop the head at the next edge.
REQ-018 On that pop, if req[head]=1, the block SHALL assert gnt[head], set gnt_id=head, clear hold_cnt and enter GRANT.
REQ-019 On that pop, if req[head]=0, the block SHALL discard the entry (stale, no grant) and stay in IDLE.
REQ-020 Clearing in_q[k] on pop SHALL take precedence over a same-cycle arrival of k.
REQ-021 A simultaneous enqueue and pop SHALL update q_count by (arrivals - 1).
REQ-022 An arrival into an empty FIFO while in IDLE SHALL produce gnt on the second edge after req is first sampled high (latency 2 cycles).
REQ-023 In GRANT, the block SHALL increment hold_cnt each cycle, saturating at MAX_HOLD.
REQ-024 In GRANT, when req[gnt_id] is sampled 0, the block SHALL clear gnt and busy at that edge and enter IDLE (normal release).
REQ-025 In GRANT with MAX_HOLD>0 and hold_cnt=MAX_HOLD-1 while req is still high, the block SHALL clear gnt at that edge, pulse timeout for 1 cycle and enter IDLE; the grant lasts exactly MAX_HOLD cycles.
REQ-026 A timed-out requester SHALL be re-queued only after dropping req and raising it again.
REQ-027 The block SHALL leave at least one IDLE cycle (gnt all zero) between consecutive grants.
REQ-028 If release and timeout coincide, the block SHALL treat the event as a normal release with no timeout pulse.
REQ-029 The granted requester raising req again after a release SHALL be a new arrival queued at the tail.

Reset
REQ-030 While rst=1, the block SHALL drive gnt=0, gnt_id=0, busy=0, q_count=0 and timeout=0.
REQ-031 While rst=1, the block SHALL clear state to IDLE, set pointers=0, in_q=0, req_d=0 and hold_cnt=0.
REQ-032 A rst assertion mid-grant SHALL drop gnt immediately (asynchronously) and discard all queued entries.
REQ-033 After rst deassertion, the block SHALL treat any req already high as an arrival on the first edge.

Verification
REQ-034 The bench SHALL drive N_REQ=3: req=001 at cycle 0 -> gnt=001 and gnt_id=0 at cycle 2; req[0] low at cycle 5 -> gnt=000 at cycle 6.
REQ-035 The bench SHALL drive req=111 raised in the same cycle, each dropped 3 cycles after its grant -> grant order 0,1,2 separated by one idle cycle; q_count sequence 3,2,1,0.
REQ-036 The bench SHALL drive MAX_HOLD=4 with req[1] held high -> gnt[1] high exactly 4 cycles, timeout pulses once, and no re-grant until req[1] toggles.
REQ-037 The bench SHALL queue req[2], then pulse it low for 1 cycle while requester 0 is granted -> single FIFO entry only; requester 2 granted once after 0 releases.
REQ-038 The bench SHALL raise req[1] while requester 0 is granted, then drop req[1] before the pop -> entry discarded, no gnt[1], q_count returns to 0.
REQ-039 The bench SHALL assert rst during GRANT with 2 entries queued -> gnt=0 and q_count=0 immediately; after release, requests still held high are re-granted in index order.

Source files
------------

// File: rtl/fcfs_arbiter.sv
// First-come-first-served arbiter: arrivals (req rising edges) are queued in a
// circular FIFO of requester indices and granted one at a time, with an optional hold timeout.
module fcfs_arbiter #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW     = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned CW      = $clog2(N_REQ + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic [CW-1:0]    q_count,
  output logic             timeout
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } stateT;

  stateT            state;
  stateT            stateNext;

  logic [N_REQ-1:0] reqD;
  logic [N_REQ-1:0] inQ;
  logic [N_REQ-1:0] inQNext;
  logic [N_REQ-1:0] arrive;
  logic [IDW-1:0]   fifo     [N_REQ];
  logic [IDW-1:0]   fifoNext [N_REQ];
  logic [IDW-1:0]   rdPtr;
  logic [IDW-1:0]   wrPtr;
  logic [IDW-1:0]   rdPtrNext;
  logic [IDW-1:0]   wrPtrNext;
  logic [IDW-1:0]   head;
  logic [CW-1:0]    nArr;
  logic [CW-1:0]    qCountNext;
  logic             pop;
  logic             popGrant;
  logic             holdExpire;
  logic             released;
  logic [HW-1:0]    holdCnt;
  logic [HW-1:0]    holdCntNext;
  logic [N_REQ-1:0] gntNext;
  logic [IDW-1:0]   gntIdNext;
  logic             timeoutNext;

  // Pointer increment wrapping modulo N_REQ (N_REQ need not be a power of two)
  function automatic logic [IDW-1:0] incPtr(input logic [IDW-1:0] p);
    return (p == IDW'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arrival detection, in-order enqueue of all same-cycle arrivals, and head pop
  always_comb begin
    arrive    = req & ~reqD & ~inQ;
    head      = fifo[rdPtr];
    pop       = (state == IDLE) && (q_count != '0);
    popGrant  = pop && req[head];
    fifoNext  = fifo;
    wrPtrNext = wrPtr;
    nArr      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arrive[i]) begin
        fifoNext[wrPtrNext] = IDW'(i);
        wrPtrNext           = incPtr(wrPtrNext);
        nArr                = nArr + 1'b1;
      end
    end
    // A popped requester's own arrival this cycle is already masked by inQ
    inQNext = inQ | arrive;
    if (pop) begin
      inQNext[head] = 1'b0;
    end
    rdPtrNext  = pop ? incPtr(rdPtr) : rdPtr;
    qCountNext = q_count + nArr - CW'(pop);
  end

  assign released   = !req[gnt_id];
  assign holdExpire = (MAX_HOLD != 0) && (holdCnt == HW'(MAX_HOLD - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (popGrant) stateNext = GRANT;
      GRANT:   if (released || holdExpire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output and hold-counter next values; a release wins over a coincident timeout
  always_comb begin
    gntNext     = gnt;
    gntIdNext   = gnt_id;
    timeoutNext = 1'b0;
    holdCntNext = holdCnt;
    case (state)
      IDLE: begin
        if (popGrant) begin
          gntNext     = N_REQ'(1) << head;
          gntIdNext   = head;
          holdCntNext = '0;
        end
      end
      GRANT: begin
        if (released) begin
          gntNext   = '0;
          gntIdNext = '0;
        end else if (holdExpire) begin
          gntNext     = '0;
          gntIdNext   = '0;
          timeoutNext = 1'b1;
        end else if (holdCnt < HW'(MAX_HOLD)) begin
          holdCntNext = holdCnt + 1'b1;
        end
      end
      default: begin
        gntNext   = '0;
        gntIdNext = '0;
      end
    endcase
  end

  // Queue, hold counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqD    <= '0;
      inQ     <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      q_count <= '0;
      holdCnt <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        fifo[i] <= '0;
      end
    end else begin
      reqD    <= req;
      inQ     <= inQNext;
      rdPtr   <= rdPtrNext;
      wrPtr   <= wrPtrNext;
      q_count <= qCountNext;
      holdCnt <= holdCntNext;
      gnt     <= gntNext;
      gnt_id  <= gntIdNext;
      busy    <= |gntNext;
      timeout <= timeoutNext;
      for (int i = 0; i < int'(N_REQ); i++) begin
        fifo[i] <= fifoNext[i];
      end
    end
  end

endmodule
